// File: rtl/spi_pkg.sv
// spi_master shared types and constants.
// Opcodes, FSM states and frame widths.
package spi_pkg;
  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DIR,
    SHIFT,
    WAIT,
    CAPTURE,
    END
  } state_e;
endpackage

// File: rtl/spi_master_shreg.sv
// Command PISO and read-byte SIPO for spi_master.
// rx_next is the byte as it will look after this cycle's capture.
module spi_master_shreg
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              capture,
  input  logic [CMD_W-1:0]  din,
  input  logic              miso,
  output logic              tx_bit,
  output logic [DATA_W-1:0] rx_next
);

  logic [CMD_W-1:0]  tx_q;
  logic [DATA_W-1:0] rx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      if (load)
        tx_q <= din;
      else if (shift)
        tx_q <= {tx_q[CMD_W-2:0], 1'b0};
      if (capture)
        rx_q <= rx_next;
    end
  end

  assign tx_bit  = tx_q[CMD_W-1];
  assign rx_next = {rx_q[DATA_W-2:0], miso};

endmodule

// File: rtl/spi_master.sv
// Single-clock SPI initiator: 10-bit command frames,
// 8-bit reply capture on read-data frames.
module spi_master
  import spi_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  opcode_e     op_q;
  logic        accept, load, shift, capture, cap_last;
  logic        tx_bit;
  logic [DATA_W-1:0] rx_next;

  spi_master_shreg u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .capture (capture),
    .din     (cmd_data),
    .miso    (MISO),
    .tx_bit  (tx_bit),
    .rx_next (rx_next)
  );

  assign accept   = (state_q == IDLE) && cmd_valid && cmd_ready;
  assign cap_last = (state_q == CAPTURE) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          load    = 1'b1;
        end
      end
      START: state_d = DIR;
      DIR: begin
        state_d = SHIFT;
        cnt_d   = 4'd9;
        shift   = 1'b1;
      end
      SHIFT: begin
        if (cnt_q == 4'd0) begin
          state_d = (op_q == RD_DATA) ? WAIT : END;
          cnt_d   = 4'(RD_LATENCY - 1);
        end else begin
          cnt_d = cnt_q - 4'd1;
          shift = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = CAPTURE;
          cnt_d   = 4'd7;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        if (cnt_q == 4'd0)
          state_d = END;
        else
          cnt_d = cnt_q - 4'd1;
      end
      END: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      op_q      <= WR_ADDR;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      done      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (accept)
        op_q <= opcode_e'(cmd_data[CMD_W-1:CMD_W-2]);
      cmd_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      SS_n      <= (state_d == IDLE) || (state_d == END);
      MOSI      <= ((state_d == DIR) || (state_d == SHIFT)) && tx_bit;
      done      <= (state_d == END);
      rsp_valid <= (state_d == END) && (op_q == RD_DATA);
      if (cap_last)
        rsp_data <= rx_next;
    end
  end

endmodule
